uart_tx_buffered: RTL

- Buffered UART transmitter for the board-side serial link to the Arduino.
- Accepts bytes from the datapath into a small FIFO, then serialises each byte as 8N1 frames on txd (LSB first), back-to-back, with no per-byte handshake.
- Contains its own baud counter and a framing FSM.
- Drives the same line and baud rate (50 MHz / 9600) as the existing receive path.

---
 rtl/uart_tx_buffered.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a baud-timed framing FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push;
  logic             pop;
  logic [7:0]       head_byte;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;
  assign push      = wr_en && !full;
  assign head_byte = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Full is judged before the edge, so a pop in the same cycle does not save the write.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing FSM and baud timing
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);
  assign txd       = txd_q;
  assign busy      = (state_q != ST_IDLE);
  assign tx_done   = (state_q == ST_STOP) && baud_last;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_last ? '0 : baud_q + BAUD_ONE;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head_byte;
          bit_idx_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^head_byte;
`endif
        end
      end

      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_last) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (baud_last) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = head_byte;
            bit_idx_d = '0;
            baud_d    = '0;
            state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^head_byte;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase

    // The line level follows the state being entered so txd changes on the same edge.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
